// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchronizer, debounce filter,
// one-cycle press/release pulses and optional hold-to-auto-repeat.
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 REPEAT_DELAY    = 25_000_000,
  parameter int                 REPEAT_RATE     = 5_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_EN       = '0,
  parameter int                 ACTIVE_LOW      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0]    DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0]    RATE_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [NUM_BTN-1:0] INV_MASK   = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  // Two-stage synchronizer; polarity is normalised so 1 always means pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw ^ INV_MASK;
      r_sync2 <= r_sync1;
    end
  end

  assign any_press = |btn_press;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      logic            w_s;
      logic            w_rise;
      logic            w_fall;
      logic            r_level;
      logic [DB_W-1:0] r_db_cnt;
      logic [RP_W-1:0] r_rp_cnt;
      logic            r_press;
      logic            r_release;
      state_t          r_state;

      assign w_s = r_sync2[gi];
      // Level edges are decoded one edge early so the pulses line up with
      // the edge at which r_level itself changes.
      assign w_rise = w_s & ~r_level & (r_db_cnt == DB_LAST);
      assign w_fall = ~w_s & r_level & (r_db_cnt == DB_LAST);

      // Debounce: count consecutive cycles of disagreement, accept on the last one.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_level  <= 1'b0;
          r_db_cnt <= '0;
        end else if (w_s == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_level  <= w_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end

      // Press/release pulses and auto-repeat sequencing; a fall overrides any repeat.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state   <= ST_IDLE;
          r_rp_cnt  <= '0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_rp_cnt  <= '0;
            r_release <= 1'b1;
          end else begin
            case (r_state)
              ST_IDLE: begin
                r_rp_cnt <= '0;
                if (w_rise) begin
                  r_press <= 1'b1;
                  r_state <= REPEAT_EN[gi] ? ST_DELAY : ST_HELD;
                end
              end
              ST_HELD: begin
                r_rp_cnt <= '0;
              end
              ST_DELAY: begin
                if (r_rp_cnt == DELAY_LAST) begin
                  r_press  <= 1'b1;
                  r_rp_cnt <= '0;
                  r_state  <= ST_REPEAT;
                end else begin
                  r_rp_cnt <= r_rp_cnt + RP_W'(1);
                end
              end
              ST_REPEAT: begin
                if (r_rp_cnt == RATE_LAST) begin
                  r_press  <= 1'b1;
                  r_rp_cnt <= '0;
                end else begin
                  r_rp_cnt <= r_rp_cnt + RP_W'(1);
                end
              end
              default: begin
                r_state  <= ST_IDLE;
                r_rp_cnt <= '0;
              end
            endcase
          end
        end
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .REPEAT_EN      (4'b0100),
    .ACTIVE_LOW     (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          any;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NB-1:0] raw, input logic [NB-1:0] level,
                     input logic [NB-1:0] press, input logic [NB-1:0] rel,
                     input logic any);
    vec_t v;
    v.raw = raw; v.level = level; v.press = press; v.rel = rel; v.any = any;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rep_pulse(input int k);
    return (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
  endfunction

  initial begin
    reset   = 1'b1;
    btn_raw = '0;

    // Table: clean press/release on ch0, then simultaneous press on ch0+ch3.
    for (int i = 0; i < 5; i++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) add(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b1001, 4'b1001, 4'b1001, 4'b0000, 1'b1);
    add(4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) add(4'b0000, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1001, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    step();
    step();
    check("reset_level", 32'(btn_level), 32'h0);
    check("reset_press", 32'(btn_press), 32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    check("reset_any", 32'(any_press), 32'h0);
    reset = 1'b0;

    foreach (vecs[n]) begin
      btn_raw = vecs[n].raw;
      step();
      check($sformatf("vec%0d_level", n), 32'(btn_level), 32'(vecs[n].level));
      check($sformatf("vec%0d_press", n), 32'(btn_press), 32'(vecs[n].press));
      check($sformatf("vec%0d_release", n), 32'(btn_release), 32'(vecs[n].rel));
      check($sformatf("vec%0d_any", n), 32'(any_press), 32'(vecs[n].any));
      $display("vec %0d raw=%b level=%b press=%b release=%b any=%b",
               n, btn_raw, btn_level, btn_press, btn_release, any_press);
    end

    // Bounce on ch1: 3 high / 1 low never reaches 4 stable cycles.
    for (int c = 0; c < 40; c++) begin
      btn_raw = ((c % 4) != 3) ? 4'b0010 : 4'b0000;
      step();
      check("bounce_level", 32'(btn_level[1]), 32'h0);
      check("bounce_press", 32'(btn_press[1]), 32'h0);
      check("bounce_release", 32'(btn_release[1]), 32'h0);
    end
    $display("bounce ch1 40 cycles level=%b", btn_level);
    btn_raw = '0;
    for (int c = 0; c < 8; c++) step();
    check("bounce_settle_level", 32'(btn_level), 32'h0);

    // Hold ch2 with auto-repeat; level should rise on the 6th edge (offset k=0).
    btn_raw = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("rep_prerise_level", 32'(btn_level[2]), 32'h0);
    end
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) step();
      else step();
      check($sformatf("rep_k%0d_level", k), 32'(btn_level[2]), 32'h1);
      check($sformatf("rep_k%0d_press", k), 32'(btn_press[2]), 32'(rep_pulse(k)));
      $display("repeat k=%0d level=%b press=%b", k, btn_level[2], btn_press[2]);
    end
    // Release: fall lands at k=28, which would otherwise be a repeat edge.
    btn_raw = 4'b0000;
    for (int k = 23; k <= 27; k++) begin
      step();
      check($sformatf("rel_k%0d_level", k), 32'(btn_level[2]), 32'h1);
      check($sformatf("rel_k%0d_press", k), 32'(btn_press[2]), 32'(rep_pulse(k)));
    end
    step();
    check("fall_level", 32'(btn_level[2]), 32'h0);
    check("fall_release", 32'(btn_release[2]), 32'h1);
    check("fall_wins_press", 32'(btn_press[2]), 32'h0);
    $display("release ch2 level=%b press=%b release=%b", btn_level, btn_press, btn_release);
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_rel_press", 32'(btn_press), 32'h0);
      check("post_rel_release", 32'(btn_release), 32'h0);
    end

    // Reset while ch2 is in REPEAT with the button still held.
    btn_raw = 4'b0100;
    for (int c = 0; c < 18; c++) step();
    check("prereset_level", 32'(btn_level), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_level", 32'(btn_level), 32'h0);
    check("async_reset_press", 32'(btn_press), 32'h0);
    check("async_reset_release", 32'(btn_release), 32'h0);
    step();
    check("held_reset_release", 32'(btn_release), 32'h0);
    check("held_reset_level", 32'(btn_level), 32'h0);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("rerise_pre_level", 32'(btn_level), 32'h0);
      check("rerise_pre_press", 32'(btn_press), 32'h0);
      check("rerise_pre_release", 32'(btn_release), 32'h0);
    end
    step();
    check("rerise_level", 32'(btn_level), 32'h4);
    check("rerise_press", 32'(btn_press), 32'h4);
    step();
    check("rerise_single_press", 32'(btn_press), 32'h0);
    $display("after reset ch2 level=%b press=%b", btn_level, btn_press);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
